// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : RV32I data-memory responder with fixed-latency valid/ready handshake
// Revision: 1.0
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         c_DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] c_CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic       c_ZERO_LAT = (LATENCY == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [c_DEPTH];

    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [2:0]        acc_funct3;
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_val;
    logic              acc_err;
    logic [3:0]        byte_en;
    logic [31:0]       wr_word;
    logic [31:0]       wr_merge;
    logic              enter_resp;
    logic              mem_we;

    // With zero latency the access happens on the accept edge, so the live
    // request fields are used instead of the captured copies.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_write  = req_write;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
        end else begin
            acc_write  = write_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
            acc_funct3 = funct3_q;
        end
    end

    always_comb begin
        word_idx = acc_addr[ADDR_W-1:2];
        lane     = acc_addr[1:0];
        rd_word  = mem[word_idx];
        ld_byte  = rd_word[{lane, 3'b000} +: 8];
        ld_half  = rd_word[{lane[1], 4'b0000} +: 16];
        acc_err  = 1'b0;
        load_val = 32'd0;
        byte_en  = 4'b0000;
        wr_word  = 32'd0;
        case (acc_funct3)
            3'b000: begin
                load_val = {{24{ld_byte[7]}}, ld_byte};
                byte_en  = 4'b0001 << lane;
                wr_word  = {4{acc_wdata[7:0]}};
            end
            3'b001: begin
                acc_err  = lane[0];
                load_val = {{16{ld_half[15]}}, ld_half};
                byte_en  = lane[1] ? 4'b1100 : 4'b0011;
                wr_word  = {2{acc_wdata[15:0]}};
            end
            3'b010: begin
                acc_err  = (lane != 2'b00);
                load_val = rd_word;
                byte_en  = 4'b1111;
                wr_word  = acc_wdata;
            end
            3'b100: begin
                acc_err  = acc_write;
                load_val = {24'd0, ld_byte};
            end
            3'b101: begin
                acc_err  = acc_write | lane[0];
                load_val = {16'd0, ld_half};
            end
            default: acc_err = 1'b1;
        endcase

        wr_merge = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                wr_merge[8*b +: 8] = wr_word[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    if (c_ZERO_LAT) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'd0 : load_val;
        end
        mem_we = enter_resp && acc_write && !acc_err && reset_n;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        write_q  <= write_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        funct3_q <= funct3_d;
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[word_idx] <= wr_merge;
        end
    end

    assign req_ready = (state_q == S_IDLE) && reset_n;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Self-checking bench for data_mem_responder at LATENCY=2 and 0
// Revision: 1.0
// ============================================================================
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [11:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] rsp_rdata  [2];

    int checks = 0;
    int errors = 0;

    // Byte-addressed reference memory, one per instance
    logic [7:0] mem_m [2][4096];

    always #5 clock = ~clock;

    // Instance 0: LATENCY=2, instance 1: LATENCY=0
    data_mem_responder #(.ADDR_W(12), .LATENCY(2)) u_dut_l2 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.ADDR_W(12), .LATENCY(0)) u_dut_l0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int exp_lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    // Reference: access size from funct3, alignment by modulo, byte-wise load/store
    function automatic void model(input int d, input bit wr, input logic [11:0] addr,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  output logic [31:0] rd, output bit er);
        int          size;
        bit          legal;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        er    = !legal || ((int'(addr) % size) != 0);
        rd    = 32'd0;
        if (er) return;
        if (wr) begin
            for (int i = 0; i < size; i++) mem_m[d][int'(addr) + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_m[d][int'(addr) + i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            rd = v;
        end
    endfunction

    // Drives one request, returns observed response, latency and handshake behaviour
    task automatic txn(input int d, input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input int hold,
                       output logic [31:0] rd, output logic er, output int lat,
                       output bit stable, output bit idle_after);
        int n;
        @(negedge clock);
        req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wd; req_funct3[d] = f3;
        req_valid[d] = 1'b1;
        rsp_ready[d] = (hold == 0);
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin @(negedge clock); lat++; end
        if (rsp_valid[d] !== 1'b1) lat = -1;
        rd = rsp_rdata[d];
        er = rsp_err[d];
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rd || rsp_err[d] !== er || req_ready[d] !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready[d] = 1'b1;
        @(negedge clock);
        idle_after = (req_ready[d] === 1'b1) && (rsp_valid[d] === 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; rsp_ready[d] = 1'b1; req_write[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; req_funct3[d] = '0;
        end
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 || rsp_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got valid=%b rdata=%h err=%b required 0/0/0",
                         d, rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            end
            checks++;
            if (req_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_req_ready[%0d]: got %b required 0", d, req_ready[d]);
            end
        end
        reset_n = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_ready[%0d]: got %b required 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_prime();
        logic [31:0] rd, erd, wd;
        logic        er;
        bit          eer, st, idl;
        int          lat;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                wd = $urandom;
                txn(d, 1'b1, 12'(w * 4), wd, 3'd2, 0, rd, er, lat, st, idl);
                model(d, 1'b1, 12'(w * 4), wd, 3'd2, erd, eer);
                checks++;
                if (er !== 1'b0 || rd !== 32'd0 || lat != exp_lat(d)) begin
                    errors++;
                    $display("FAIL prime_sw[%0d][%0d]: got err=%b rdata=%h lat=%0d required 0/0/%0d",
                             d, w, er, rd, lat, exp_lat(d));
                end
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] rd;
        bit          er;
    } vec_t;

    task automatic test_directed();
        vec_t        tbl [10];
        logic [31:0] rd, erd;
        logic        er;
        bit          eer, st, idl;
        int          lat;
        tbl = '{
            '{1'b1, 12'h010, 32'hDEADBEEF, 3'd2, 32'h00000000, 1'b0},
            '{1'b0, 12'h010, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0},
            '{1'b1, 12'h011, 32'h00000055, 3'd0, 32'h00000000, 1'b0},
            '{1'b0, 12'h011, 32'h0,        3'd0, 32'h00000055, 1'b0},
            '{1'b0, 12'h012, 32'h0,        3'd1, 32'hFFFFDEAD, 1'b0},
            '{1'b0, 12'h012, 32'h0,        3'd5, 32'h0000DEAD, 1'b0},
            '{1'b0, 12'h013, 32'h0,        3'd4, 32'h000000DE, 1'b0},
            '{1'b0, 12'h013, 32'h0,        3'd2, 32'h00000000, 1'b1},
            '{1'b1, 12'h011, 32'h00001234, 3'd1, 32'h00000000, 1'b1},
            '{1'b0, 12'h010, 32'h0,        3'd2, 32'hDEAD55EF, 1'b0}
        };
        for (int i = 0; i < 10; i++) begin
            txn(0, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, 0, rd, er, lat, st, idl);
            model(0, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, erd, eer);
            checks++;
            if (rd !== tbl[i].rd || er !== tbl[i].er) begin
                errors++;
                $display("FAIL directed[%0d]: got rdata=%h err=%b required rdata=%h err=%b",
                         i, rd, er, tbl[i].rd, tbl[i].er);
            end
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL directed_lat[%0d]: got %0d required 3", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, erd;
        logic        er;
        bit          eer, st, idl;
        int          lat;
        txn(0, 1'b0, 12'h010, 32'h0, 3'd2, 5, rd, er, lat, st, idl);
        model(0, 1'b0, 12'h010, 32'h0, 3'd2, erd, eer);
        checks++;
        if (rd !== erd || er !== eer) begin
            errors++;
            $display("FAIL bp_data: got %h/%b required %h/%b", rd, er, erd, eer);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL bp_stable: got unstable response or req_ready=1, required stable");
        end
        checks++;
        if (!idl) begin
            errors++;
            $display("FAIL bp_idle_after: got busy required idle after handshake");
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd, erd;
        logic        er;
        bit          eer, st, idl, quiet;
        int          lat, n;
        model(0, 1'b0, 12'h020, 32'h0, 3'd2, erd, eer);
        @(negedge clock);
        req_write[0] = 1'b1; req_addr[0] = 12'h020; req_wdata[0] = 32'h11111111;
        req_funct3[0] = 3'd2; req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL mr_accept_ready: got %b required 1", req_ready[0]);
        end
        @(negedge clock);
        req_valid[0] = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL mr_in_reset: got ready=%b valid=%b required 0/0", req_ready[0], rsp_valid[0]);
        end
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (rsp_valid[0] !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL mr_no_response: got rsp_valid=1 required 0 after abort");
        end
        txn(0, 1'b0, 12'h020, 32'h0, 3'd2, 0, rd, er, lat, st, idl);
        checks++;
        if (rd !== erd || er !== 1'b0) begin
            errors++;
            $display("FAIL mr_prior_contents: got %h/%b required %h/0", rd, er, erd);
        end

        @(negedge clock);
        req_write[0] = 1'b0; req_addr[0] = 12'h024; req_funct3[0] = 3'd2;
        req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
        @(negedge clock);
        req_valid[0] = 1'b0;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 10) begin @(negedge clock); n++; end
        checks++;
        if (rsp_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL rr_reach_resp: got rsp_valid=%b required 1", rsp_valid[0]);
        end
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL rr_dropped: got valid=%b rdata=%h err=%b required 0/0/0",
                     rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        end
        reset_n = 1'b1;
        rsp_ready[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rr_ready_after: got %b required 1", req_ready[0]);
        end
    endtask

    task automatic test_random(input int d, input int count);
        logic [31:0] rd, erd, wd;
        logic [11:0] a;
        logic [2:0]  f3;
        logic        er;
        bit          wr, eer, st, idl;
        int          lat, hold;
        for (int i = 0; i < count; i++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = 12'($urandom_range(0, 63));
            f3   = 3'($urandom_range(0, 7));
            wd   = $urandom;
            hold = $urandom_range(0, 2);
            txn(d, wr, a, wd, f3, hold, rd, er, lat, st, idl);
            model(d, wr, a, wd, f3, erd, eer);
            checks++;
            if (rd !== erd || er !== eer) begin
                errors++;
                $display("FAIL rand[%0d][%0d] wr=%b a=%h f3=%0d: got %h/%b required %h/%b",
                         d, i, wr, a, f3, rd, er, erd, eer);
            end
            checks++;
            if (lat != exp_lat(d) || !st || !idl) begin
                errors++;
                $display("FAIL rand_hs[%0d][%0d]: got lat=%0d stable=%b idle=%b required %0d/1/1",
                         d, i, lat, st, idl, exp_lat(d));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        bit          eer_q [$];
        logic [31:0] erd, wd;
        logic [11:0] a;
        logic [2:0]  f3;
        bit          eer, wr, alt_ok, prev_ready;
        int          accepts;
        accepts = 0;
        alt_ok = 1'b1;
        prev_ready = 1'b0;
        @(negedge clock);
        rsp_ready[1] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (rsp_valid[1] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected[%0d]: got rsp_valid=1 required 0", i);
                end else begin
                    erd = exp_q.pop_front();
                    eer = eer_q.pop_front();
                    if (rsp_rdata[1] !== erd || rsp_err[1] !== eer) begin
                        errors++;
                        $display("FAIL b2b_rsp[%0d]: got %h/%b required %h/%b",
                                 i, rsp_rdata[1], rsp_err[1], erd, eer);
                    end
                end
            end
            if (i > 0 && req_ready[1] === prev_ready) alt_ok = 1'b0;
            prev_ready = req_ready[1];
            wr = 1'($urandom_range(0, 1));
            a  = 12'($urandom_range(0, 63));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            req_write[1] = wr; req_addr[1] = a; req_wdata[1] = wd; req_funct3[1] = f3;
            req_valid[1] = 1'b1;
            if (req_ready[1] === 1'b1) begin
                model(1, wr, a, wd, f3, erd, eer);
                exp_q.push_back(erd);
                eer_q.push_back(eer);
                accepts++;
            end
            @(negedge clock);
        end
        req_valid[1] = 1'b0;
        checks++;
        if (accepts != 12 || !alt_ok) begin
            errors++;
            $display("FAIL b2b_rate: got accepts=%0d alternating=%b required 12/1", accepts, alt_ok);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d outstanding required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_random(0, 40);
        test_random(1, 24);
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 12, is the byte-address width; storage SHALL be 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal range 0..15, is the number of wait cycles between request accept and response.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_funct3  input  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  requester accepts the response.
REQ-013 rsp_rdata  output  32  load result, sign- or zero-extended.
REQ-014 rsp_err  output  1  request was misaligned or had an illegal funct3.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid=1 and req_ready=1, and all request fields SHALL be captured at acceptance.
REQ-017 On accept, the FSM SHALL go IDLE->WAIT with the wait counter loaded to LATENCY-1, or IDLE->RESP directly when LATENCY=0.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP, giving exactly LATENCY+1 cycles from the accept edge to rsp_valid=1.
REQ-019 The memory access (read sample or store commit) SHALL occur on the edge entering RESP.
REQ-020 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL stay stable until a cycle with rsp_ready=1; that cycle SHALL return the FSM to IDLE.
REQ-021 A new request SHALL NOT be accepted in the same cycle as a response handshake (no overlap; throughput is at most one request per LATENCY+2 cycles).
REQ-022 Word index = addr[ADDR_W-1:2]; byte lane = addr[1:0]; halfword lane = addr[1].
REQ-023 Stores: SB SHALL write wdata[7:0] to the addressed byte lane only.
REQ-024 Stores: SH SHALL write wdata[15:0] to the addressed halfword only.
REQ-025 Stores: SW SHALL write the full word.
REQ-026 Unwritten bytes SHALL be preserved on every store.
REQ-027 A store response SHALL carry rsp_rdata=0.
REQ-028 Loads: LB/LH SHALL sign-extend the addressed byte/halfword, LBU/LHU SHALL zero-extend it, and LW SHALL return the full word.
REQ-029 Error cases: halfword access with addr[0]=1, word access with addr[1:0]!=00, or funct3 in {011,110,111} (loads), or funct3 not in {000,001,010} (stores), SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-030 An errored store SHALL NOT modify memory; an errored request SHALL still follow the normal latency and handshake.
REQ-031 rsp_err SHALL be 0 on all legal requests.
REQ-032 The top address bits are never out of range, since depth is 2^(ADDR_W-2).

Reset
REQ-033 While reset_n=0 at a rising edge: FSM->IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-034 req_ready SHALL read 0 during any cycle in which reset_n=0.
REQ-035 Reset asserted in WAIT SHALL abort the pending request; an uncommitted store SHALL NOT write memory.
REQ-036 Reset asserted in RESP SHALL drop the response.
REQ-037 Memory contents SHALL NOT be cleared by reset.
REQ-038 After reset_n returns to 1, req_ready SHALL be 1 on the next cycle.

Verification
REQ-039 LATENCY=2: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_valid exactly 3 cycles after each accept; the load returns 0xDEADBEEF with rsp_err=0.
REQ-040 Starting from word 0xDEADBEEF at 0x010: SB 0x011 data 0x55, then LB 0x011 -> 0x00000055; LH 0x012 -> 0xFFFFDEAD; LHU 0x012 -> 0x0000DEAD; LBU 0x013 -> 0x000000DE.
REQ-041 Misalignment: LW 0x013 -> rsp_err=1, rsp_rdata=0. SH 0x011 data 0x1234 -> rsp_err=1, and a subsequent LW 0x010 returns the word unchanged.
REQ-042 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0 throughout; rsp_ready=1 -> IDLE on the next cycle.
REQ-043 Reset mid-operation: accept SW 0x020 data 0x11111111 and pulse reset_n=0 while in WAIT -> no response; a subsequent LW 0x020 returns the prior contents.
REQ-044 LATENCY=0: accept LW -> rsp_valid=1 on the cycle after accept; back-to-back requests with rsp_ready held at 1 -> one accept every 2 cycles.
